// File: rtl/ahb_lite_pkg.sv
// Shared types and constants for the AHB-Lite RAM slave front end.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // Data-phase state of the slave
  typedef enum logic [2:0] {
    StIdle,
    StWrDp,
    StRdDp,
    StRdStall,
    StRdDone,
    StErr1,
    StErr2
  } state_t;

endpackage

// File: rtl/ahb_lite_ram_slave.sv
// AHB-Lite slave front end for a write-priority dual-port RAM.
// Address phases are registered into a data-phase FSM; reads are issued to the RAM directly
// from the address phase so that read data lines up with the following data phase. A read
// that follows a write is delayed by one wait state because the RAM port is busy writing.
module ahb_lite_ram_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              RAM_WRITE,
  output logic              RAM_READ,
  output logic [31:0]       RAM_WR_ADDR,
  output logic [DATA_W-1:0] RAM_WR_DATA,
  output logic [31:0]       RAM_RD_ADDR,
  input  logic [DATA_W-1:0] RAM_RD_DATA
);

  localparam int unsigned PadW = 32 - ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                hwrite_q, hwrite_d;

  htrans_t             trans;
  logic [ADDR_W-1:0]   haddr_idx;
  logic                slot_free;
  logic                accept;
  logic                legal;
  logic                read_issue;
  logic                unused_haddr;

  assign trans     = htrans_t'(HTRANS);
  assign haddr_idx = HADDR[ADDR_W+1:2];
  // Upper byte-address bits beyond the RAM depth are deliberately ignored
  assign unused_haddr = ^HADDR[31:ADDR_W+2];

  // Stall and first error cycle never take a new address phase
  assign slot_free  = (state_q != StRdStall) && (state_q != StErr1);
  assign accept     = HSEL && HREADY && ((trans == HtransNonseq) || (trans == HtransSeq)) &&
                      !RST && slot_free;
  assign legal      = (HSIZE == HSIZE_WORD) && (HADDR[1:0] == 2'b00);
  // A read behind a write cannot use the RAM this cycle; it is reissued from RD_STALL
  assign read_issue = accept && legal && !HWRITE && (state_q != StWrDp);

  // Next-state and address/control latch
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hwrite_d = hwrite_q;
    case (state_q)
      StRdStall: state_d = StRdDone;
      StErr1:    state_d = StErr2;
      default: begin
        if (accept) begin
          idx_d    = haddr_idx;
          hwrite_d = HWRITE;
          if (!legal) begin
            state_d = StErr1;
          end else if (HWRITE) begin
            state_d = StWrDp;
          end else if (state_q == StWrDp) begin
            state_d = StRdStall;
          end else begin
            state_d = StRdDp;
          end
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      hwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hwrite_q <= hwrite_d;
    end
  end

  // Bus response and RAM strobes; everything is forced idle while reset is held
  always_comb begin
    HREADYOUT   = 1'b1;
    HRESP       = RESP_OKAY;
    HRDATA      = '0;
    RAM_WRITE   = 1'b0;
    RAM_READ    = 1'b0;
    RAM_WR_ADDR = '0;
    RAM_WR_DATA = '0;
    RAM_RD_ADDR = '0;
    if (!RST) begin
      case (state_q)
        StWrDp: begin
          RAM_WRITE   = hwrite_q;
          RAM_WR_ADDR = {{PadW{1'b0}}, idx_q};
          RAM_WR_DATA = HWDATA;
        end
        StRdDp, StRdDone: begin
          HRDATA = RAM_RD_DATA;
        end
        StRdStall: begin
          HREADYOUT   = 1'b0;
          RAM_READ    = 1'b1;
          RAM_RD_ADDR = {{PadW{1'b0}}, idx_q};
        end
        StErr1: begin
          HREADYOUT = 1'b0;
          HRESP     = RESP_ERROR;
        end
        StErr2: begin
          HRESP = RESP_ERROR;
        end
        default: ;
      endcase
      if (read_issue) begin
        RAM_READ    = 1'b1;
        RAM_RD_ADDR = {{PadW{1'b0}}, haddr_idx};
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
// Bench for ahb_lite_ram_slave with a behavioural write-priority RAM behind it.
// The driver pushes the expected data-phase responses; a monitor tracks data phases on the bus
// and pops one expectation for every data-phase cycle it sees.
module tb_ahb_lite_ram_slave;
  import ahb_lite_pkg::*;

  logic        CLK;
  logic        RST;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        RAM_WRITE;
  logic        RAM_READ;
  logic [31:0] RAM_WR_ADDR;
  logic [31:0] RAM_WR_DATA;
  logic [31:0] RAM_RD_ADDR;
  logic [31:0] RAM_RD_DATA;

  // Single-slave bus: the bus ready is the slave's own ready
  assign HREADY = HREADYOUT;

  ahb_lite_ram_slave #(
    .ADDR_W(10),
    .DATA_W(32)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRDATA     (HRDATA),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .RAM_WRITE  (RAM_WRITE),
    .RAM_READ   (RAM_READ),
    .RAM_WR_ADDR(RAM_WR_ADDR),
    .RAM_WR_DATA(RAM_WR_DATA),
    .RAM_RD_ADDR(RAM_RD_ADDR),
    .RAM_RD_DATA(RAM_RD_DATA)
  );

  // Behavioural RAM: registered read, data valid the cycle after RAM_READ
  logic [31:0] mem [0:1023];
  logic [31:0] ram_rd_q;
  assign RAM_RD_DATA = ram_rd_q;
  always_ff @(posedge CLK) begin
    if (RAM_WRITE) mem[RAM_WR_ADDR[9:0]] <= RAM_WR_DATA;
    if (RAM_READ)  ram_rd_q <= mem[RAM_RD_ADDR[9:0]];
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  typedef struct {
    string       name;
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
    logic        wr;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_chk;
    logic [31:0] rd_addr;
  } exp_t;

  exp_t sb_q[$];

  function automatic void push(input string name, input logic rdy, input logic resp,
                               input logic [31:0] rdata, input logic wr,
                               input logic [31:0] wr_addr, input logic [31:0] wr_data,
                               input logic rd_chk, input logic [31:0] rd_addr);
    exp_t e;
    e.name = name; e.rdy = rdy; e.resp = resp; e.rdata = rdata; e.wr = wr;
    e.wr_addr = wr_addr; e.wr_data = wr_data; e.rd_chk = rd_chk; e.rd_addr = rd_addr;
    sb_q.push_back(e);
  endfunction

  function automatic void push_wr(input string name, input logic [31:0] idx,
                                  input logic [31:0] data);
    push(name, 1'b1, 1'b0, 32'h0, 1'b1, idx, data, 1'b0, 32'h0);
  endfunction

  function automatic void push_rd(input string name, input logic [31:0] data);
    push(name, 1'b1, 1'b0, data, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endfunction

  function automatic void push_stall(input string name, input logic [31:0] idx);
    push(name, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, idx);
  endfunction

  function automatic void push_err(input string name);
    push({name, "_e1"}, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    push({name, "_e2"}, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endfunction

  // Monitor: a data phase starts after an accepted address phase and ends on a ready cycle
  initial begin
    logic dp;
    logic acc;
    logic rdy;
    exp_t e;
    dp = 1'b0;
    forever begin
      @(negedge CLK);
      if (RAM_WRITE || RAM_READ)
        check("strobe_excl", 64'(RAM_WRITE & RAM_READ), 64'(0));
      if (dp && !RST) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'(sb_q.size()), 64'(1));
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_rsp"}, 64'({HREADYOUT, HRESP, RAM_WRITE}),
                64'({e.rdy, e.resp, e.wr}));
          check({e.name, "_rdata"}, 64'(HRDATA), 64'(e.rdata));
          if (e.wr) begin
            check({e.name, "_wr_addr"}, 64'(RAM_WR_ADDR), 64'(e.wr_addr));
            check({e.name, "_wr_data"}, 64'(RAM_WR_DATA), 64'(e.wr_data));
          end
          if (e.rd_chk)
            check({e.name, "_rd_strobe"}, 64'({RAM_READ, RAM_RD_ADDR}), {31'h0, 1'b1, e.rd_addr});
        end
      end
      acc = HSEL && HREADY && HTRANS[1];
      rdy = HREADY;
      @(posedge CLK);
      if (RST) dp = 1'b0;
      else begin
        if (rdy) dp = 1'b0;
        if (acc) dp = 1'b1;
      end
    end
  end

  // Drive one address phase and hold it until the bus accepts it; HWDATA follows
  task automatic issue(input htrans_t trans, input logic write, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int   n;
    logic rdy;
    HSEL   = 1'b1;
    HTRANS = trans;
    HWRITE = write;
    HSIZE  = size;
    HADDR  = addr;
    n = 0;
    do begin
      @(negedge CLK);
      rdy = HREADY;
      @(posedge CLK);
      n++;
    end while (!rdy && n < 16);
    if (!rdy) check("issue_timeout", 64'(rdy), 64'(1));
    #1;
    HWDATA = wdata;
  endtask

  task automatic idle_cycle();
    HSEL   = 1'b0;
    HTRANS = HtransIdle;
    HWRITE = 1'b0;
    HSIZE  = HSIZE_WORD;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST    = 1'b1;
    HSEL   = 1'b0;
    HADDR  = 32'h0;
    HTRANS = HtransIdle;
    HWRITE = 1'b0;
    HSIZE  = HSIZE_WORD;
    HWDATA = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_ctrl", 64'({HREADYOUT, HRESP, RAM_WRITE, RAM_READ}), 64'(4'b1000));
    check("reset_hrdata", 64'(HRDATA), 64'(0));
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("idle_ctrl", 64'({HREADYOUT, HRESP, RAM_WRITE, RAM_READ}), 64'(4'b1000));
    check("idle_hrdata", 64'(HRDATA), 64'(0));
    @(posedge CLK);
    #1;

    // Plain writes, including the preload of word 5
    push_wr("wr_10", 32'd4, 32'hDEADBEEF);
    issue(HtransNonseq, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
    idle_cycle();
    push_wr("wr_14", 32'd5, 32'h12345678);
    issue(HtransNonseq, 1'b1, HSIZE_WORD, 32'h14, 32'h12345678);
    idle_cycle();

    // Write then read of the same word: one wait state, new data returned
    push_wr("raw_a_wr", 32'd4, 32'hA5A5A5A5);
    issue(HtransNonseq, 1'b1, HSIZE_WORD, 32'h10, 32'hA5A5A5A5);
    push_stall("raw_a_stall", 32'd4);
    push_rd("raw_a_done", 32'hA5A5A5A5);
    issue(HtransNonseq, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    idle_cycle();
    idle_cycle();
    push_wr("raw_b_wr", 32'd4, 32'hDEADBEEF);
    issue(HtransNonseq, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
    push_stall("raw_b_stall", 32'd4);
    push_rd("raw_b_done", 32'hDEADBEEF);
    issue(HtransNonseq, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    idle_cycle();
    idle_cycle();

    // Zero-wait read burst from idle
    push_rd("rd_10", 32'hDEADBEEF);
    issue(HtransNonseq, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    push_rd("rd_14_seq", 32'h12345678);
    issue(HtransSeq, 1'b0, HSIZE_WORD, 32'h14, 32'h0);
    idle_cycle();

    // Upper address bits above the RAM depth select the same word
    push_rd("rd_hi_addr", 32'hDEADBEEF);
    issue(HtransNonseq, 1'b0, HSIZE_WORD, 32'hFFFF_F010, 32'h0);
    idle_cycle();

    // Illegal size: error response, no write
    push_wr("wr_20", 32'd8, 32'hCAFEF00D);
    issue(HtransNonseq, 1'b1, HSIZE_WORD, 32'h20, 32'hCAFEF00D);
    idle_cycle();
    push_err("err_size");
    issue(HtransNonseq, 1'b1, 3'b000, 32'h20, 32'hFFFFFFFF);
    idle_cycle();
    idle_cycle();

    // Misaligned read errors; a read pipelined behind it is accepted in ERR2
    push_err("err_align");
    issue(HtransNonseq, 1'b0, HSIZE_WORD, 32'h22, 32'h0);
    push_rd("rd_14_after_err", 32'h12345678);
    issue(HtransNonseq, 1'b0, HSIZE_WORD, 32'h14, 32'h0);
    idle_cycle();
    push_rd("rd_20_unchanged", 32'hCAFEF00D);
    issue(HtransNonseq, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    idle_cycle();

    // BUSY while selected: no RAM access, no data phase
    HSEL = 1'b1; HTRANS = HtransBusy; HWRITE = 1'b0; HADDR = 32'h10;
    @(negedge CLK);
    check("busy_no_read", 64'(RAM_READ), 64'(0));
    @(posedge CLK);
    #1;
    idle_cycle();
    @(negedge CLK);
    check("busy_after", 64'({HREADYOUT, HRESP, RAM_WRITE, RAM_READ}), 64'(4'b1000));
    @(posedge CLK);
    #1;

    // Reset while a write data phase is pending: the write must not reach the RAM
    issue(HtransNonseq, 1'b1, HSIZE_WORD, 32'h20, 32'h13579BDF);
    HSEL = 1'b0; HTRANS = HtransIdle;
    RST = 1'b1;
    @(negedge CLK);
    check("abort_no_wr", 64'(RAM_WRITE), 64'(0));
    @(posedge CLK);
    #1 RST = 1'b0;
    push_rd("rd_20_after_abort", 32'hCAFEF00D);
    issue(HtransNonseq, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    idle_cycle();

    // Reset during RD_STALL abandons the read
    push_wr("rst_wr", 32'd4, 32'h5A5A5A5A);
    issue(HtransNonseq, 1'b1, HSIZE_WORD, 32'h10, 32'h5A5A5A5A);
    push_stall("rst_stall", 32'd4);
    issue(HtransNonseq, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    HSEL = 1'b0; HTRANS = HtransIdle;
    @(negedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_stall_ctrl", 64'({HREADYOUT, HRESP, RAM_READ}), 64'(3'b100));
    check("rst_stall_hrdata", 64'(HRDATA), 64'(0));
    @(posedge CLK);
    #1;

    repeat (3) idle_cycle();
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
